uart_pix_pack: RTL and testbench

//  Sits between uart_rx and the SDRAM write FIFO. Hunts for a 2-byte frame header in the

---
 rtl/uart_pix_pack_pkg.sv | 13 +
 rtl/uart_pix_pack.sv | 179 +++++++++++++++++
 tb/tb_uart_pix_pack.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_pix_pack_pkg.sv
// Shared definitions for uart_pix_pack: FSM state encoding and default frame header bytes.
package uart_pix_pack_pkg;
  typedef enum logic [1:0] {
    S_HUNT = 2'd0,
    S_HDR1 = 2'd1,
    S_DATA = 2'd2,
    S_CHK  = 2'd3
  } state_t;

  localparam logic [7:0] HDR0_DEF = 8'h55;
  localparam logic [7:0] HDR1_DEF = 8'hAA;
  localparam int         PIX_W    = 24;
endpackage

// File: rtl/uart_pix_pack.sv
// UART byte stream to pixel-word packer with header hunt, per-frame pixel count and idle timeout.
// Optional trailing checksum byte is enabled by defining UART_PIX_CHKSUM_EN.
module uart_pix_pack
  import uart_pix_pack_pkg::*;
#(
  parameter int          BYTES_PER_PIX = 1,
  parameter int          FRAME_PIX     = 384000,
  parameter logic [7:0]  HDR0          = HDR0_DEF,
  parameter logic [7:0]  HDR1          = HDR1_DEF,
  parameter int          TIMEOUT_CYC   = 100000
) (
  input  logic             sclk,
  input  logic             s_rst_n,
  input  logic [7:0]       rx_data,
  input  logic             po_flag,
  output logic [PIX_W-1:0] pix_data,
  output logic             pix_vld,
  output logic             frame_start,
  output logic             frame_done,
  output logic             busy,
  output logic             err_timeout,
  output logic             chk_err
);

  localparam int PC_W = $clog2(FRAME_PIX + 1);
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

  state_t          state, state_nxt;
  logic [1:0]      byte_cnt;
  logic [PC_W-1:0] pix_cnt;
  logic [TO_W-1:0] to_cnt;
  logic [15:0]     shift_p0;
  logic            hdr_ok, pix_done, last_pix, to_fire, done_evt;
  logic            byte_last, pix_last;

  // Keeps only the low BYTES_PER_PIX bytes; the oldest byte lands most significant.
  function automatic logic [PIX_W-1:0] pack_pix(input logic [15:0] sh, input logic [7:0] b);
    case (BYTES_PER_PIX)
      1:       return {16'd0, b};
      2:       return {8'd0, sh[7:0], b};
      default: return {sh, b};
    endcase
  endfunction

  assign byte_last = (byte_cnt == 2'(BYTES_PER_PIX - 1));
  assign pix_last  = (pix_cnt == PC_W'(FRAME_PIX - 1));
  assign to_fire   = (state != S_HUNT) && !po_flag && (to_cnt == TO_W'(TIMEOUT_CYC - 1));

`ifdef UART_PIX_CHKSUM_EN
  logic chk_byte;
  assign done_evt = chk_byte;
`else
  assign done_evt = last_pix;
`endif

  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) state <= S_HUNT;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    hdr_ok    = 1'b0;
    pix_done  = 1'b0;
    last_pix  = 1'b0;
`ifdef UART_PIX_CHKSUM_EN
    chk_byte  = 1'b0;
`endif
    case (state)
      S_HUNT: if (po_flag && rx_data == HDR0) state_nxt = S_HDR1;
      S_HDR1: begin
        if (po_flag) begin
          if (rx_data == HDR1) begin
            state_nxt = S_DATA;
            hdr_ok    = 1'b1;
          end else if (rx_data != HDR0) begin
            state_nxt = S_HUNT;
          end
        end else if (to_fire) begin
          state_nxt = S_HUNT;
        end
      end
      S_DATA: begin
        if (po_flag) begin
          if (byte_last) begin
            pix_done = 1'b1;
            if (pix_last) begin
              last_pix = 1'b1;
`ifdef UART_PIX_CHKSUM_EN
              state_nxt = S_CHK;
`else
              state_nxt = S_HUNT;
`endif
            end
          end
        end else if (to_fire) begin
          state_nxt = S_HUNT;
        end
      end
`ifdef UART_PIX_CHKSUM_EN
      S_CHK: begin
        if (po_flag) begin
          chk_byte  = 1'b1;
          state_nxt = S_HUNT;
        end else if (to_fire) begin
          state_nxt = S_HUNT;
        end
      end
`endif
      default: state_nxt = S_HUNT;
    endcase
  end

  // Stage p0: byte shift register, byte/pixel counters and idle timer
  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      byte_cnt <= '0;
      pix_cnt  <= '0;
      to_cnt   <= '0;
      shift_p0 <= '0;
    end else begin
      if (po_flag || state == S_HUNT || to_fire) to_cnt <= '0;
      else                                        to_cnt <= to_cnt + 1'b1;
      if (hdr_ok || to_fire) begin
        byte_cnt <= '0;
        pix_cnt  <= '0;
        shift_p0 <= '0;
      end else if (po_flag && state == S_DATA) begin
        shift_p0 <= {shift_p0[7:0], rx_data};
        byte_cnt <= byte_last ? 2'd0 : byte_cnt + 1'b1;
        if (pix_done) pix_cnt <= last_pix ? '0 : pix_cnt + 1'b1;
      end
    end
  end

  // Stage p1: registered pixel word and one-cycle status strobes
  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      pix_data    <= '0;
      pix_vld     <= 1'b0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      busy        <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      pix_vld     <= pix_done;
      frame_start <= hdr_ok;
      frame_done  <= done_evt;
      err_timeout <= to_fire;
      busy        <= (busy | hdr_ok) & ~(done_evt | to_fire);
      if (pix_done) pix_data <= pack_pix(shift_p0, rx_data);
    end
  end

`ifdef UART_PIX_CHKSUM_EN
  logic [7:0] sum_p0;

  function automatic logic [7:0] add_mod256(input logic [7:0] a, input logic [7:0] b);
    return a + b;
  endfunction

  // Running byte sum of the frame; the mismatch flag survives until the next header
  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      sum_p0  <= '0;
      chk_err <= 1'b0;
    end else if (hdr_ok) begin
      sum_p0  <= '0;
      chk_err <= 1'b0;
    end else begin
      if (po_flag && state == S_DATA) sum_p0 <= add_mod256(sum_p0, rx_data);
      if (chk_byte && rx_data != sum_p0) chk_err <= 1'b1;
    end
  end
`else
  assign chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_pix_pack.sv
// Bench for uart_pix_pack: one BPP=1 and one BPP=3 instance, table vectors plus scoreboarded frames.
module tb_uart_pix_pack;
  localparam int FP = 4;
  localparam int TO = 200;
`ifdef UART_PIX_CHKSUM_EN
  localparam logic CHK = 1'b1;
`else
  localparam logic CHK = 1'b0;
`endif

  logic        sclk = 1'b0;
  logic        s_rst_n = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        po1 = 1'b0, po3 = 1'b0;
  logic [23:0] pd1, pd3;
  logic        pv1, pv3, fs1, fs3, fd1, fd3, bz1, bz3, to1, to3, ce1, ce3;

  int n_tests = 0;
  int n_fail  = 0;
  int cnt_pv1 = 0, cnt_fs1 = 0, cnt_fd1 = 0;
  int cnt_pv3 = 0, cnt_fs3 = 0, cnt_fd3 = 0, cnt_to3 = 0;
  logic [23:0] q1[$];
  logic [23:0] q3[$];

  always #5 sclk = ~sclk;

  uart_pix_pack #(.BYTES_PER_PIX(1), .FRAME_PIX(FP), .TIMEOUT_CYC(TO)) u_dut1 (
    .sclk(sclk), .s_rst_n(s_rst_n), .rx_data(rx_data), .po_flag(po1),
    .pix_data(pd1), .pix_vld(pv1), .frame_start(fs1), .frame_done(fd1),
    .busy(bz1), .err_timeout(to1), .chk_err(ce1));

  uart_pix_pack #(.BYTES_PER_PIX(3), .FRAME_PIX(FP), .TIMEOUT_CYC(TO)) u_dut3 (
    .sclk(sclk), .s_rst_n(s_rst_n), .rx_data(rx_data), .po_flag(po3),
    .pix_data(pd3), .pix_vld(pv3), .frame_start(fs3), .frame_done(fd3),
    .busy(bz3), .err_timeout(to3), .chk_err(ce3));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboards: every pixel strobe must match the oldest pending expected pixel
  always @(negedge sclk) begin
    if (pv1) begin
      cnt_pv1++;
      if (q1.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL sb_dut1_extra: got pixel %06h expected none", pd1);
      end else check("sb_dut1_pix", 64'(pd1), 64'(q1.pop_front()));
    end
    if (pv3) begin
      cnt_pv3++;
      if (q3.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL sb_dut3_extra: got pixel %06h expected none", pd3);
      end else check("sb_dut3_pix", 64'(pd3), 64'(q3.pop_front()));
    end
    if (fs1) cnt_fs1++;
    if (fd1) cnt_fd1++;
    if (fs3) cnt_fs3++;
    if (fd3) cnt_fd3++;
    if (to3) cnt_to3++;
  end

  task automatic send(input bit s3, input logic [7:0] b);
    @(negedge sclk);
    rx_data = b;
    if (s3) po3 = 1'b1; else po1 = 1'b1;
    @(negedge sclk);
    po1 = 1'b0;
    po3 = 1'b0;
  endtask

  task automatic settle();
    repeat (2) @(negedge sclk);
    #1;
  endtask

  // Sends header, FP pixels of bytes first+step*i, and the checksum trailer when enabled
  task automatic send_frame(input bit s3, input logic [7:0] first, input logic [7:0] step);
    int bpp;
    logic [23:0] acc;
    logic [7:0]  sum, b;
    bpp = s3 ? 3 : 1;
    acc = '0;
    sum = '0;
    send(s3, 8'h55);
    send(s3, 8'hAA);
    for (int i = 0; i < FP * bpp; i++) begin
      b   = first + 8'(step * i);
      acc = (bpp == 3) ? {acc[15:0], b} : {16'd0, b};
      sum = sum + b;
      if ((i % bpp) == bpp - 1) begin
        if (s3) q3.push_back(acc); else q1.push_back(acc);
      end
      send(s3, b);
    end
`ifdef UART_PIX_CHKSUM_EN
    send(s3, sum);
`endif
  endtask

  task automatic send_pix1(input logic [7:0] b);
    q1.push_back({16'd0, b});
    send(1'b0, b);
  endtask

  typedef struct {
    logic [7:0]  b;
    logic        vld;
    logic [23:0] data;
    logic        fs;
    logic        fd;
    logic        bz;
  } tv_t;

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    tv_t tv[$];
    int  c_pv, c_fd, c_fs, got;

    tv.push_back('{8'h55, 1'b0, 24'h000000, 1'b0, 1'b0, 1'b0});
    tv.push_back('{8'hAA, 1'b0, 24'h000000, 1'b1, 1'b0, 1'b1});
    tv.push_back('{8'h01, 1'b1, 24'h000001, 1'b0, 1'b0, 1'b1});
    tv.push_back('{8'h02, 1'b1, 24'h000002, 1'b0, 1'b0, 1'b1});
    tv.push_back('{8'h03, 1'b1, 24'h000003, 1'b0, 1'b0, 1'b1});
    tv.push_back('{8'h04, 1'b1, 24'h000004, 1'b0, !CHK, CHK});
`ifdef UART_PIX_CHKSUM_EN
    tv.push_back('{8'h0A, 1'b0, 24'h000004, 1'b0, 1'b1, 1'b0});
`endif

    repeat (3) @(negedge sclk);
    #1;
    check("reset_dut1", 64'({pd1, pv1, fs1, fd1, bz1, to1, ce1}), 64'd0);
    check("reset_dut3", 64'({pd3, pv3, fs3, fd3, bz3, to3, ce3}), 64'd0);
    @(negedge sclk);
    s_rst_n = 1'b1;

    // Test 1: BPP=1 frame, cycle-by-cycle table
    foreach (tv[i]) begin
      if (tv[i].vld) q1.push_back(tv[i].data);
      send(1'b0, tv[i].b);
      check($sformatf("t1_row%0d", i), 64'({pv1, pd1, fs1, fd1, bz1}),
            64'({tv[i].vld, tv[i].data, tv[i].fs, tv[i].fd, tv[i].bz}));
    end

    // Test 2: BPP=3 frame 11 22 33 ... CC
    c_pv = cnt_pv3; c_fd = cnt_fd3; c_fs = cnt_fs3;
    send_frame(1'b1, 8'h11, 8'h11);
    settle();
    check("t2_pix_count", 64'(cnt_pv3 - c_pv), 64'd4);
    check("t2_frame_done", 64'(cnt_fd3 - c_fd), 64'd1);
    check("t2_frame_start", 64'(cnt_fs3 - c_fs), 64'd1);
    check("t2_hold_data", 64'(pd3), 64'h00AABBCC);
    check("t2_busy_low", 64'(bz3), 64'd0);

    // Test 3: header slip 55 55 AA, then false header 55 12 AA
    c_fs = cnt_fs1;
    send(1'b0, 8'h55);
    send(1'b0, 8'h55);
    send(1'b0, 8'hAA);
    check("t3_slip_start", 64'({fs1, bz1}), 64'b11);
    for (int i = 0; i < FP; i++) send_pix1(8'h07 + 8'(i));
`ifdef UART_PIX_CHKSUM_EN
    send(1'b0, 8'h22);
`endif
    settle();
    check("t3_slip_one_start", 64'(cnt_fs1 - c_fs), 64'd1);
    check("t3_frame_closed", 64'(bz1), 64'd0);
    c_fs = cnt_fs1;
    send(1'b0, 8'h55);
    send(1'b0, 8'h12);
    send(1'b0, 8'hAA);
    send(1'b0, 8'h01);
    settle();
    check("t3_false_hdr_start", 64'(cnt_fs1 - c_fs), 64'd0);
    check("t3_false_hdr_busy", 64'(bz1), 64'd0);

    // Test 4: partial pixel then idle timeout, then clean frame
    c_pv = cnt_pv3; c_fd = cnt_fd3;
    send(1'b1, 8'h55);
    send(1'b1, 8'hAA);
    send(1'b1, 8'h11);
    send(1'b1, 8'h22);
    got = 0;
    for (int n = 1; n <= 300; n++) begin
      @(negedge sclk);
      if (to3) begin
        got = n;
        break;
      end
    end
    check("t4_timeout_cycle", 64'(got), 64'(TO));
    check("t4_busy_cleared", 64'(bz3), 64'd0);
    settle();
    check("t4_timeout_pulses", 64'(cnt_to3), 64'd1);
    check("t4_no_partial_pix", 64'(cnt_pv3 - c_pv), 64'd0);
    send_frame(1'b1, 8'h01, 8'h01);
    settle();
    check("t4_clean_pix", 64'(cnt_pv3 - c_pv), 64'd4);
    check("t4_clean_done", 64'(cnt_fd3 - c_fd), 64'd1);

    // Test 5: checksum trailer
`ifdef UART_PIX_CHKSUM_EN
    send(1'b0, 8'h55);
    send(1'b0, 8'hAA);
    for (int i = 1; i <= 4; i++) send_pix1(8'(i));
    send(1'b0, 8'h0A);
    check("t5_good_sum", 64'({fd1, ce1}), 64'b10);
    send(1'b0, 8'h55);
    send(1'b0, 8'hAA);
    for (int i = 1; i <= 4; i++) send_pix1(8'(i));
    check("t5_no_done_before_trailer", 64'(fd1), 64'd0);
    send(1'b0, 8'h0B);
    check("t5_bad_sum", 64'({fd1, ce1}), 64'b11);
    settle();
    check("t5_sticky", 64'(ce1), 64'd1);
    send(1'b0, 8'h55);
    send(1'b0, 8'hAA);
    check("t5_cleared_on_start", 64'({fs1, ce1}), 64'b10);
    for (int i = 1; i <= 4; i++) send_pix1(8'(i));
    send(1'b0, 8'h0A);
`else
    check("t5_chk_err_tied_dut1", 64'(ce1), 64'd0);
    check("t5_chk_err_tied_dut3", 64'(ce3), 64'd0);
`endif

    // Test 6: reset after two pixels, then a fresh frame counted from zero
    send(1'b0, 8'h55);
    send(1'b0, 8'hAA);
    send_pix1(8'h31);
    send_pix1(8'h32);
    @(negedge sclk);
    s_rst_n = 1'b0;
    #1;
    check("t6_reset_immediate", 64'({pd1, pv1, fs1, fd1, bz1, to1, ce1}), 64'd0);
    repeat (3) @(negedge sclk);
    #1;
    check("t6_reset_hold", 64'({pd1, pv1, fs1, fd1, bz1, to1, ce1}), 64'd0);
    @(negedge sclk);
    s_rst_n = 1'b1;
    c_pv = cnt_pv1; c_fd = cnt_fd1;
    send_frame(1'b0, 8'h21, 8'h01);
    settle();
    check("t6_pix_after_reset", 64'(cnt_pv1 - c_pv), 64'd4);
    check("t6_done_after_reset", 64'(cnt_fd1 - c_fd), 64'd1);
    check("t6_busy_low", 64'(bz1), 64'd0);

    check("end_q1_drained", 64'(q1.size()), 64'd0);
    check("end_q3_drained", 64'(q3.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
